stream_mux_nto1: RTL and testbench

//  Parametrised N-to-1 stream multiplexer; successor to the 16-bit 2-to-1 combinational mux.

---
 rtl/stream_mux_nto1.sv | 131 +++++++++++++
 tb/tb_stream_mux_nto1.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/stream_mux_nto1.sv
// N-to-1 valid/ready stream mux with a registered output stage.
// The grant is either a fixed channel (sel) or round-robin starting from rr_ptr.

module stream_mux_lane #(
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic [SEL_W-1:0] rr_ptr,
  input  logic             valid,
  output logic             req,
  output logic             req_hi
);
  localparam logic [SEL_W-1:0] ID = SEL_W'(IDX);

  // req_hi marks lanes at or after rr_ptr, which take priority over the wrapped-around lanes
  assign req    = valid & (mode | (sel == ID));
  assign req_hi = req & (ID >= rr_ptr);
endmodule

module stream_mux_nto1 #(
  parameter int DATA_BITS = 16,
  parameter int NUM_CH    = 4,
  parameter int SEL_W     = $clog2(NUM_CH),
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mode,
  input  logic [SEL_W-1:0]            sel,
  input  logic [NUM_CH-1:0]           in_valid,
  input  logic [NUM_CH*DATA_BITS-1:0] in_data,
  output logic [NUM_CH-1:0]           in_ready,
  output logic                        out_valid,
  output logic [DATA_BITS-1:0]        out_data,
  output logic [SEL_W-1:0]            out_ch,
  input  logic                        out_ready,
  output logic [CNT_W-1:0]            xfer_cnt
);
  typedef struct packed {
    logic [SEL_W-1:0]     ch;
    logic [DATA_BITS-1:0] data;
  } out_t;

  out_t                 out_d, out_q;
  logic                 out_valid_d, out_valid_q;
  logic [CNT_W-1:0]     cnt_d, cnt_q;
  logic [SEL_W-1:0]     rr_d, rr_q;

  logic [NUM_CH-1:0]    req, req_hi;
  logic                 gnt_vld, load, accept;
  logic [SEL_W-1:0]     gnt_idx;
  logic [DATA_BITS-1:0] gnt_data;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
      stream_mux_lane #(.SEL_W(SEL_W), .IDX(gi)) u_lane (
        .mode   (mode),
        .sel    (sel),
        .rr_ptr (rr_q),
        .valid  (in_valid[gi]),
        .req    (req[gi]),
        .req_hi (req_hi[gi])
      );
    end
  endgenerate

  // Lowest requester at/after rr_ptr wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    gnt_vld = |req;
    gnt_idx = '0;
    for (int i = NUM_CH-1; i >= 0; i--)
      if (req[i]) gnt_idx = SEL_W'(i);
    for (int i = NUM_CH-1; i >= 0; i--)
      if (req_hi[i]) gnt_idx = SEL_W'(i);
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (gnt_idx == SEL_W'(i)) gnt_data = in_data[i*DATA_BITS +: DATA_BITS];
  end

  assign load   = ~out_valid_q | out_ready;
  assign accept = gnt_vld & load;

  // in_ready is forced low while reset is held, since the empty register would otherwise look loadable
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_CH; i++)
      in_ready[i] = gnt_vld & (gnt_idx == SEL_W'(i)) & load & rst_n;
  end

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    if (accept) begin
      out_d.data  = gnt_data;
      out_d.ch    = gnt_idx;
      out_valid_d = 1'b1;
      cnt_d       = cnt_q + CNT_W'(1);
      if (mode)
        rr_d = (gnt_idx == SEL_W'(NUM_CH-1)) ? '0 : gnt_idx + SEL_W'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      rr_q        <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_q.data;
  assign out_ch    = out_q.ch;
  assign xfer_cnt  = cnt_q;
endmodule

// File: tb/tb_stream_mux_nto1.sv
// Directed bench for stream_mux_nto1; a 4-bit-counter twin shares the inputs to reach counter wrap quickly.
module tb_stream_mux_nto1;
  localparam int DB = 16, NC = 4, SW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mode;
  logic [SW-1:0] sel;
  logic [NC-1:0] in_valid;
  logic [NC*DB-1:0] in_data;
  logic [NC-1:0] in_ready, w_in_ready;
  logic          out_valid, w_out_valid;
  logic [DB-1:0] out_data, w_out_data;
  logic [SW-1:0] out_ch, w_out_ch;
  logic          out_ready;
  logic [15:0]   xfer_cnt;
  logic [3:0]    w_xfer_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stream_mux_nto1 #(.DATA_BITS(DB), .NUM_CH(NC), .SEL_W(SW), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_ready(out_ready), .xfer_cnt(xfer_cnt)
  );

  stream_mux_nto1 #(.DATA_BITS(DB), .NUM_CH(NC), .SEL_W(SW), .CNT_W(4)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_valid(in_valid), .in_data(in_data),
    .in_ready(w_in_ready), .out_valid(w_out_valid), .out_data(w_out_data), .out_ch(w_out_ch),
    .out_ready(out_ready), .xfer_cnt(w_xfer_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b0;
    in_data = {16'h4444, 16'hA5A5, 16'h2222, 16'h1111};
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_cnt",       32'(xfer_cnt),  32'd0);

    // fixed select, ch2
    mode = 1'b0; sel = 3'd2; in_valid = 4'hF; out_ready = 1'b1;
    #1 chk("rst_in_ready_gated", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("fix_in_ready", 32'(in_ready), 32'b0100);
    tick;
    chk("fix_valid", 32'(out_valid), 32'd1);
    chk("fix_data",  32'(out_data),  32'hA5A5);
    chk("fix_ch",    32'(out_ch),    32'd2);
    chk("fix_cnt1",  32'(xfer_cnt),  32'd1);
    tick;
    chk("fix_cnt2",  32'(xfer_cnt),  32'd2);
    chk("fix_valid2", 32'(out_valid), 32'd1);

    // round-robin, all channels valid; rr_ptr still 0
    mode = 1'b1;
    tick; chk("rr_a0", 32'(out_ch), 32'd0); chk("rr_a0_data", 32'(out_data), 32'h1111);
    tick; chk("rr_a1", 32'(out_ch), 32'd1);
    tick; chk("rr_a2", 32'(out_ch), 32'd2);
    tick; chk("rr_a3", 32'(out_ch), 32'd3); chk("rr_a3_data", 32'(out_data), 32'h4444);
    tick; chk("rr_a4", 32'(out_ch), 32'd0);
    chk("rr_cnt7", 32'(xfer_cnt), 32'd7);

    // only ch1 and ch3 valid, rr_ptr = 1
    in_valid = 4'b1010;
    tick; chk("rr_b0", 32'(out_ch), 32'd1);
    tick; chk("rr_b1", 32'(out_ch), 32'd3);
    tick; chk("rr_b2", 32'(out_ch), 32'd1); chk("rr_b2_data", 32'(out_data), 32'h2222);
    tick; chk("rr_b3", 32'(out_ch), 32'd3);
    chk("rr_cnt11", 32'(xfer_cnt), 32'd11);

    // backpressure holding ch3 word
    out_ready = 1'b0;
    #1 chk("bp_in_ready", 32'(in_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data",  32'(out_data),  32'h4444);
      chk("bp_ch",    32'(out_ch),    32'd3);
      chk("bp_in_ready_hold", 32'(in_ready), 32'd0);
    end
    chk("bp_cnt", 32'(xfer_cnt), 32'd11);
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(in_ready), 32'b0010);
    tick;
    chk("bp_drain_valid", 32'(out_valid), 32'd1);
    chk("bp_drain_ch",    32'(out_ch),    32'd1);
    chk("bp_drain_data",  32'(out_data),  32'h2222);
    chk("bp_drain_cnt",   32'(xfer_cnt),  32'd12);

    // out-of-range sel: no grant, register drains
    mode = 1'b0; sel = 3'd5; in_valid = 4'hF;
    #1 chk("sel5_in_ready", 32'(in_ready), 32'd0);
    tick;
    chk("sel5_valid", 32'(out_valid), 32'd0);
    chk("sel5_data",  32'(out_data),  32'h2222);
    chk("sel5_ch",    32'(out_ch),    32'd1);
    chk("sel5_cnt",   32'(xfer_cnt),  32'd12);
    tick;
    chk("sel5_valid2", 32'(out_valid), 32'd0);

    // counter wrap on the 4-bit twin: 12 -> 15 -> 0
    sel = 3'd0;
    repeat (3) tick;
    chk("wrap_pre",      32'(w_xfer_cnt), 32'hF);
    tick;
    chk("wrap_zero",     32'(w_xfer_cnt), 32'h0);
    chk("wrap_main_cnt", 32'(xfer_cnt),   32'd16);
    chk("wrap_main_ch",  32'(out_ch),     32'd0);

    // async reset mid-stream with out_valid=1 (rr_ptr was 2 before reset)
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid",    32'(out_valid),  32'd0);
    chk("arst_data",     32'(out_data),   32'd0);
    chk("arst_ch",       32'(out_ch),     32'd0);
    chk("arst_cnt",      32'(xfer_cnt),   32'd0);
    chk("arst_in_ready", 32'(in_ready),   32'd0);
    chk("arst_wcnt",     32'(w_xfer_cnt), 32'd0);
    mode = 1'b1;
    tick;
    rst_n = 1'b1;
    #1 chk("arst_rr_ptr0", 32'(in_ready), 32'b0001);
    tick;
    chk("arst_first_ch", 32'(out_ch),   32'd0);
    chk("arst_first_cnt", 32'(xfer_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
